// File: rtl/ub_controller.sv
// ---------------------------------------------------------------------------
// ub_controller
//
// Sequencer and round-robin arbiter in front of the single-port unified
// buffer. Two requesters (FIFO side and compute side) issue read or write
// bursts with an auto-incrementing address. A granted burst owns the buffer
// until its last word completes or the buffer fails to answer in time.
//
// Ports (X = fifo | comp):
//   clk_i, rst_i              clock, synchronous active-high reset
//   X_req_*                   burst request handshake (write, addr, len-1)
//   X_wdata_*                 write-data handshake into the controller
//   X_rdata_*                 read-data handshake out of the controller
//   ub_we_o / ub_re_o         one-cycle write / read strobe to the buffer
//   ub_fifo_en_o / ub_compute_en_o  side select, held through the access
//   ub_address_o              buffer address, held through the access
//   ub_fifo_in_o / ub_compute_in_o  write word presented to the buffer
//   ub_fifo_out_i / ub_compute_out_i read word returned by the buffer
//   ub_done_i                 buffer completion, one cycle after a strobe
//   busy_o                    a burst is in progress
//   burst_done_o              pulse when the last word of a burst completes
//   timeout_err_o             pulse when a burst is aborted on timeout
// ---------------------------------------------------------------------------
module ub_controller #(
  parameter int BUFFER_SIZE        = 1024,
  parameter int FIFO_DATA_WIDTH    = 8,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int ADDRESS_SIZE       = $clog2(BUFFER_SIZE),
  parameter int LEN_WIDTH          = 8,
  parameter int TIMEOUT            = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,

  input  logic                          fifo_req_valid_i,
  output logic                          fifo_req_ready_o,
  input  logic                          fifo_req_write_i,
  input  logic [ADDRESS_SIZE-1:0]       fifo_req_addr_i,
  input  logic [LEN_WIDTH-1:0]          fifo_req_len_i,
  input  logic                          fifo_wdata_valid_i,
  output logic                          fifo_wdata_ready_o,
  input  logic [FIFO_DATA_WIDTH-1:0]    fifo_wdata_i,
  output logic                          fifo_rdata_valid_o,
  input  logic                          fifo_rdata_ready_i,
  output logic [FIFO_DATA_WIDTH-1:0]    fifo_rdata_o,

  input  logic                          comp_req_valid_i,
  output logic                          comp_req_ready_o,
  input  logic                          comp_req_write_i,
  input  logic [ADDRESS_SIZE-1:0]       comp_req_addr_i,
  input  logic [LEN_WIDTH-1:0]          comp_req_len_i,
  input  logic                          comp_wdata_valid_i,
  output logic                          comp_wdata_ready_o,
  input  logic [COMPUTE_DATA_WIDTH-1:0] comp_wdata_i,
  output logic                          comp_rdata_valid_o,
  input  logic                          comp_rdata_ready_i,
  output logic [COMPUTE_DATA_WIDTH-1:0] comp_rdata_o,

  output logic                          ub_we_o,
  output logic                          ub_re_o,
  output logic                          ub_compute_en_o,
  output logic                          ub_fifo_en_o,
  output logic [ADDRESS_SIZE-1:0]       ub_address_o,
  output logic [FIFO_DATA_WIDTH-1:0]    ub_fifo_in_o,
  output logic [COMPUTE_DATA_WIDTH-1:0] ub_compute_in_o,
  input  logic [FIFO_DATA_WIDTH-1:0]    ub_fifo_out_i,
  input  logic [COMPUTE_DATA_WIDTH-1:0] ub_compute_out_i,
  input  logic                          ub_done_i,

  output logic                          busy_o,
  output logic                          burst_done_o,
  output logic                          timeout_err_o
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR = ADDRESS_SIZE'(BUFFER_SIZE - 1);
  localparam logic [TIMER_W-1:0]      TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    ISSUE,
    WAIT,
    RDATA
  } state_e;

  state_e                          state_q, state_d;
  logic                            side_q, side_d;     // 0 = fifo, 1 = comp
  logic                            last_q, last_d;     // side granted last
  logic                            write_q, write_d;
  logic [ADDRESS_SIZE-1:0]         addr_q, addr_d;
  logic [LEN_WIDTH-1:0]            remain_q, remain_d;
  logic [TIMER_W-1:0]              timer_q, timer_d;
  logic [FIFO_DATA_WIDTH-1:0]      fifo_wbuf_q, fifo_wbuf_d;
  logic [COMPUTE_DATA_WIDTH-1:0]   comp_wbuf_q, comp_wbuf_d;
  logic [FIFO_DATA_WIDTH-1:0]      fifo_rdata_q, fifo_rdata_d;
  logic [COMPUTE_DATA_WIDTH-1:0]   comp_rdata_q, comp_rdata_d;

  logic grant_comp;
  logic advance;
  logic access;

  // State and datapath registers. The round-robin pointer resets to "compute
  // granted last" so that the FIFO side wins the first tie after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      side_q       <= 1'b0;
      last_q       <= 1'b1;
      write_q      <= 1'b0;
      addr_q       <= '0;
      remain_q     <= '0;
      timer_q      <= '0;
      fifo_wbuf_q  <= '0;
      comp_wbuf_q  <= '0;
      fifo_rdata_q <= '0;
      comp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      last_q       <= last_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      timer_q      <= timer_d;
      fifo_wbuf_q  <= fifo_wbuf_d;
      comp_wbuf_q  <= comp_wbuf_d;
      fifo_rdata_q <= fifo_rdata_d;
      comp_rdata_q <= comp_rdata_d;
    end
  end

  // Next-state and output decode. Every handshake output is qualified with
  // the granted side so the idle requester never sees a ready/valid.
  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    last_d       = last_q;
    write_d      = write_q;
    addr_d       = addr_q;
    remain_d     = remain_q;
    timer_d      = timer_q;
    fifo_wbuf_d  = fifo_wbuf_q;
    comp_wbuf_d  = comp_wbuf_q;
    fifo_rdata_d = fifo_rdata_q;
    comp_rdata_d = comp_rdata_q;

    grant_comp         = 1'b0;
    advance            = 1'b0;
    fifo_req_ready_o   = 1'b0;
    comp_req_ready_o   = 1'b0;
    fifo_wdata_ready_o = 1'b0;
    comp_wdata_ready_o = 1'b0;
    fifo_rdata_valid_o = 1'b0;
    comp_rdata_valid_o = 1'b0;
    ub_we_o            = 1'b0;
    ub_re_o            = 1'b0;
    burst_done_o       = 1'b0;
    timeout_err_o      = 1'b0;

    case (state_q)
      IDLE: begin
        // Reset gates the grant so a request held through reset is not
        // acknowledged while the block is being cleared.
        if (!rst_i && (fifo_req_valid_i || comp_req_valid_i)) begin
          grant_comp = comp_req_valid_i && (!fifo_req_valid_i || !last_q);
          side_d     = grant_comp;
          last_d     = grant_comp;
          if (grant_comp) begin
            comp_req_ready_o = 1'b1;
            write_d          = comp_req_write_i;
            addr_d           = comp_req_addr_i;
            remain_d         = comp_req_len_i;
            state_d          = comp_req_write_i ? WDATA : ISSUE;
          end else begin
            fifo_req_ready_o = 1'b1;
            write_d          = fifo_req_write_i;
            addr_d           = fifo_req_addr_i;
            remain_d         = fifo_req_len_i;
            state_d          = fifo_req_write_i ? WDATA : ISSUE;
          end
        end
      end

      WDATA: begin
        if (side_q) begin
          comp_wdata_ready_o = 1'b1;
          if (comp_wdata_valid_i) begin
            comp_wbuf_d = comp_wdata_i;
            state_d     = ISSUE;
          end
        end else begin
          fifo_wdata_ready_o = 1'b1;
          if (fifo_wdata_valid_i) begin
            fifo_wbuf_d = fifo_wdata_i;
            state_d     = ISSUE;
          end
        end
      end

      ISSUE: begin
        ub_we_o = write_q;
        ub_re_o = !write_q;
        timer_d = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (ub_done_i) begin
          if (write_q) begin
            advance = 1'b1;
          end else begin
            if (side_q) comp_rdata_d = ub_compute_out_i;
            else        fifo_rdata_d = ub_fifo_out_i;
            state_d = RDATA;
          end
        end else if (timer_q == TIMER_LAST) begin
          timeout_err_o = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      RDATA: begin
        if (side_q) begin
          comp_rdata_valid_o = 1'b1;
          advance            = comp_rdata_ready_i;
        end else begin
          fifo_rdata_valid_o = 1'b1;
          advance            = fifo_rdata_ready_i;
        end
      end

      default: state_d = IDLE;
    endcase

    // Word completion: either close the burst or step to the next word,
    // wrapping explicitly so non-power-of-two buffers stay in range.
    if (advance) begin
      if (remain_q == '0) begin
        burst_done_o = 1'b1;
        state_d      = IDLE;
      end else begin
        addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        remain_d = remain_q - 1'b1;
        state_d  = write_q ? WDATA : ISSUE;
      end
    end
  end

  // Buffer side selection and address are held for the whole access
  // (strobe cycle plus the wait for completion) and are zero otherwise.
  always_comb begin
    access          = (state_q == ISSUE) || (state_q == WAIT);
    ub_fifo_en_o    = access && !side_q;
    ub_compute_en_o = access && side_q;
    ub_address_o    = access ? addr_q : '0;
  end

  assign ub_fifo_in_o    = fifo_wbuf_q;
  assign ub_compute_in_o = comp_wbuf_q;
  assign fifo_rdata_o    = fifo_rdata_q;
  assign comp_rdata_o    = comp_rdata_q;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: tb/tb_ub_controller.sv
module tb_ub_controller;

  logic       clk = 1'b0;
  logic       rst;

  logic       fifo_req_valid, fifo_req_ready, fifo_req_write;
  logic [9:0] fifo_req_addr;
  logic [7:0] fifo_req_len;
  logic       fifo_wdata_valid, fifo_wdata_ready;
  logic [7:0] fifo_wdata;
  logic       fifo_rdata_valid, fifo_rdata_ready;
  logic [7:0] fifo_rdata;

  logic       comp_req_valid, comp_req_ready, comp_req_write;
  logic [9:0] comp_req_addr;
  logic [7:0] comp_req_len;
  logic       comp_wdata_valid, comp_wdata_ready;
  logic [3:0] comp_wdata;
  logic       comp_rdata_valid, comp_rdata_ready;
  logic [3:0] comp_rdata;

  logic       ub_we, ub_re, ub_compute_en, ub_fifo_en;
  logic [9:0] ub_address;
  logic [7:0] ub_fifo_in;
  logic [3:0] ub_compute_in;
  logic [7:0] ub_fifo_out = 8'h00;
  logic [3:0] ub_compute_out = 4'h0;
  logic       ub_done = 1'b0;
  logic       busy, burst_done, timeout_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ub_controller dut (
    .clk_i(clk), .rst_i(rst),
    .fifo_req_valid_i(fifo_req_valid), .fifo_req_ready_o(fifo_req_ready),
    .fifo_req_write_i(fifo_req_write), .fifo_req_addr_i(fifo_req_addr),
    .fifo_req_len_i(fifo_req_len),
    .fifo_wdata_valid_i(fifo_wdata_valid), .fifo_wdata_ready_o(fifo_wdata_ready),
    .fifo_wdata_i(fifo_wdata),
    .fifo_rdata_valid_o(fifo_rdata_valid), .fifo_rdata_ready_i(fifo_rdata_ready),
    .fifo_rdata_o(fifo_rdata),
    .comp_req_valid_i(comp_req_valid), .comp_req_ready_o(comp_req_ready),
    .comp_req_write_i(comp_req_write), .comp_req_addr_i(comp_req_addr),
    .comp_req_len_i(comp_req_len),
    .comp_wdata_valid_i(comp_wdata_valid), .comp_wdata_ready_o(comp_wdata_ready),
    .comp_wdata_i(comp_wdata),
    .comp_rdata_valid_o(comp_rdata_valid), .comp_rdata_ready_i(comp_rdata_ready),
    .comp_rdata_o(comp_rdata),
    .ub_we_o(ub_we), .ub_re_o(ub_re), .ub_compute_en_o(ub_compute_en),
    .ub_fifo_en_o(ub_fifo_en), .ub_address_o(ub_address),
    .ub_fifo_in_o(ub_fifo_in), .ub_compute_in_o(ub_compute_in),
    .ub_fifo_out_i(ub_fifo_out), .ub_compute_out_i(ub_compute_out),
    .ub_done_i(ub_done),
    .busy_o(busy), .burst_done_o(burst_done), .timeout_err_o(timeout_err)
  );

  // Unified buffer model: acts shortly after each rising edge, sees the
  // strobe of the current cycle and answers with done one cycle later.
  // Compute-side words are zero-extended on store; reads return low bits.
  logic [7:0] mem [1024] = '{default: 8'h00};
  logic       pend = 1'b0;
  logic       withhold = 1'b0;

  always @(posedge clk) begin
    #2;
    ub_done = pend && !withhold;
    pend    = ub_we || ub_re;
    if (ub_we) mem[ub_address] = ub_fifo_en ? ub_fifo_in : {4'h0, ub_compute_in};
    if (ub_re) begin
      ub_fifo_out    = mem[ub_address];
      ub_compute_out = mem[ub_address][3:0];
    end
  end

  // Monitor sampled on the falling edge: records strobes, grants and pulses
  // and counts any violation of the exclusivity rules.
  logic [9:0] strobeAddr [$];
  bit         strobeFifo [$];
  bit         strobeWe [$];
  bit         grants [$];
  int cycleNo = 0;
  int reCycle = 0;
  int toCycle = 0;
  int burstDoneCnt = 0;
  int timeoutCnt = 0;
  int viol = 0;

  always @(negedge clk) begin
    cycleNo++;
    if (burst_done) burstDoneCnt++;
    if (timeout_err) begin
      timeoutCnt++;
      toCycle = cycleNo;
    end
    if (!rst) begin
      if (ub_we && ub_re) viol++;
      if (ub_fifo_en && ub_compute_en) viol++;
      if (fifo_req_ready && comp_req_ready) viol++;
      if (fifo_wdata_ready && comp_wdata_ready) viol++;
      if (fifo_rdata_valid && comp_rdata_valid) viol++;
      if (ub_re && (fifo_rdata_valid || comp_rdata_valid)) viol++;
      if (ub_we || ub_re) begin
        strobeAddr.push_back(ub_address);
        strobeFifo.push_back(ub_fifo_en);
        strobeWe.push_back(ub_we);
        reCycle = cycleNo;
      end
      if (fifo_req_ready) grants.push_back(1'b0);
      if (comp_req_ready) grants.push_back(1'b1);
    end
  end

  typedef struct packed {
    logic            side;
    logic            write;
    logic [9:0]      addr;
    logic [7:0]      len;
    logic [3:0][7:0] data;
    logic [3:0][9:0] expAddr;
    logic [3:0]      stall;
  } vec_t;

  function automatic vec_t mkVec(input logic side, input logic write,
                                 input logic [9:0] addr, input logic [7:0] len,
                                 input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] d3,
                                 input logic [9:0] a0, input logic [9:0] a1,
                                 input logic [9:0] a2, input logic [9:0] a3,
                                 input logic [3:0] stall);
    vec_t v;
    v.side = side; v.write = write; v.addr = addr; v.len = len;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
    v.expAddr[0] = a0; v.expAddr[1] = a1; v.expAddr[2] = a2; v.expAddr[3] = a3;
    v.stall = stall;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dropRequests();
    fifo_req_valid = 1'b0;
    comp_req_valid = 1'b0;
  endtask

  // Runs one complete burst from a table record and checks data, strobe
  // addresses, side enables, strobe kind and the completion pulse.
  task automatic applyStimulus(input int idx, input vec_t v);
    int n, cnt, sBase, bdStart, toStart;
    logic [7:0] got;
    n       = int'(v.len) + 1;
    sBase   = strobeAddr.size();
    bdStart = burstDoneCnt;
    toStart = timeoutCnt;
    tick();
    if (!v.side) begin
      fifo_req_valid = 1'b1; fifo_req_write = v.write;
      fifo_req_addr = v.addr; fifo_req_len = v.len;
    end else begin
      comp_req_valid = 1'b1; comp_req_write = v.write;
      comp_req_addr = v.addr; comp_req_len = v.len;
    end
    #1;
    cnt = 0;
    while (!(v.side ? comp_req_ready : fifo_req_ready) && cnt < 50) begin
      tick(); cnt++;
    end
    checkOutput($sformatf("v%0d_grant", idx), 64'(cnt < 50), 64'd1);
    tick();
    dropRequests();
    for (int i = 0; i < n; i++) begin
      if (v.write) begin
        fifo_wdata = v.data[i];
        comp_wdata = v.data[i][3:0];
        if (!v.side) fifo_wdata_valid = 1'b1; else comp_wdata_valid = 1'b1;
        #1;
        cnt = 0;
        while (!(v.side ? comp_wdata_ready : fifo_wdata_ready) && cnt < 50) begin
          tick(); cnt++;
        end
        checkOutput($sformatf("v%0d_wready%0d", idx, i), 64'(cnt < 50), 64'd1);
        tick();
        fifo_wdata_valid = 1'b0;
        comp_wdata_valid = 1'b0;
      end else begin
        cnt = 0;
        while (!(v.side ? comp_rdata_valid : fifo_rdata_valid) && cnt < 50) begin
          tick(); cnt++;
        end
        checkOutput($sformatf("v%0d_rvalid%0d", idx, i), 64'(cnt < 50), 64'd1);
        repeat (int'(v.stall)) tick();
        if (v.stall != 0)
          checkOutput($sformatf("v%0d_rhold%0d", idx, i),
                      64'(v.side ? comp_rdata_valid : fifo_rdata_valid), 64'd1);
        got = v.side ? {4'h0, comp_rdata} : fifo_rdata;
        checkOutput($sformatf("v%0d_rdata%0d", idx, i), 64'(got),
                    64'(v.side ? {4'h0, v.data[i][3:0]} : v.data[i]));
        if (!v.side) fifo_rdata_ready = 1'b1; else comp_rdata_ready = 1'b1;
        tick();
        fifo_rdata_ready = 1'b0;
        comp_rdata_ready = 1'b0;
      end
    end
    cnt = 0;
    while (busy && cnt < 50) begin
      tick(); cnt++;
    end
    checkOutput($sformatf("v%0d_idle", idx), 64'(busy), 64'd0);
    checkOutput($sformatf("v%0d_burst_done", idx), 64'(burstDoneCnt - bdStart), 64'd1);
    checkOutput($sformatf("v%0d_no_timeout", idx), 64'(timeoutCnt - toStart), 64'd0);
    checkOutput($sformatf("v%0d_strobes", idx), 64'(strobeAddr.size() - sBase), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (sBase + i < strobeAddr.size()) begin
        checkOutput($sformatf("v%0d_addr%0d", idx, i), 64'(strobeAddr[sBase + i]), 64'(v.expAddr[i]));
        checkOutput($sformatf("v%0d_fifo_en%0d", idx, i), 64'(strobeFifo[sBase + i]), 64'(!v.side));
        checkOutput($sformatf("v%0d_we%0d", idx, i), 64'(strobeWe[sBase + i]), 64'(v.write));
      end
    end
  endtask

  function automatic logic [63:0] allOutputs();
    return 64'({fifo_req_ready, fifo_wdata_ready, fifo_rdata_valid, fifo_rdata,
                comp_req_ready, comp_wdata_ready, comp_rdata_valid, comp_rdata,
                ub_we, ub_re, ub_compute_en, ub_fifo_en, ub_address,
                ub_fifo_in, ub_compute_in, busy, burst_done, timeout_err});
  endfunction

  vec_t vecs [8];
  vec_t postReset;

  initial begin
    int cnt, bdStart, toStart, gBase;

    vecs[0] = mkVec(0, 1, 10'd10,   8'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 10'd10,   10'd0,    10'd0, 10'd0, 4'd0);
    vecs[1] = mkVec(0, 0, 10'd10,   8'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 10'd10,   10'd0,    10'd0, 10'd0, 4'd0);
    vecs[2] = mkVec(1, 1, 10'd1022, 8'd3, 8'h01, 8'h02, 8'h03, 8'h04, 10'd1022, 10'd1023, 10'd0, 10'd1, 4'd0);
    vecs[3] = mkVec(1, 0, 10'd1022, 8'd3, 8'h01, 8'h02, 8'h03, 8'h04, 10'd1022, 10'd1023, 10'd0, 10'd1, 4'd0);
    vecs[4] = mkVec(0, 0, 10'd1022, 8'd2, 8'h01, 8'h02, 8'h03, 8'h00, 10'd1022, 10'd1023, 10'd0, 10'd0, 4'd5);
    vecs[5] = mkVec(0, 1, 10'd1023, 8'd1, 8'h3C, 8'hC3, 8'h00, 8'h00, 10'd1023, 10'd0,    10'd0, 10'd0, 4'd0);
    vecs[6] = mkVec(1, 0, 10'd1023, 8'd1, 8'h3C, 8'hC3, 8'h00, 8'h00, 10'd1023, 10'd0,    10'd0, 10'd0, 4'd2);
    vecs[7] = mkVec(0, 1, 10'd5,    8'd0, 8'h5A, 8'h00, 8'h00, 8'h00, 10'd5,    10'd0,    10'd0, 10'd0, 4'd0);
    postReset = mkVec(0, 0, 10'd5,  8'd0, 8'h5A, 8'h00, 8'h00, 8'h00, 10'd5,    10'd0,    10'd0, 10'd0, 4'd0);

    // Arbitration from reset: both sides request read bursts continuously.
    rst = 1'b1;
    fifo_req_valid = 1'b1; fifo_req_write = 1'b0; fifo_req_addr = 10'd10; fifo_req_len = 8'd0;
    comp_req_valid = 1'b1; comp_req_write = 1'b0; comp_req_addr = 10'd20; comp_req_len = 8'd0;
    fifo_wdata_valid = 1'b0; fifo_wdata = 8'h00;
    comp_wdata_valid = 1'b0; comp_wdata = 4'h0;
    fifo_rdata_ready = 1'b1; comp_rdata_ready = 1'b1;
    repeat (3) tick();
    checkOutput("reset_outputs", allOutputs(), 64'd0);
    gBase   = grants.size();
    bdStart = burstDoneCnt;
    rst = 1'b0;
    cnt = 0;
    while (grants.size() - gBase < 4 && cnt < 200) begin
      tick(); cnt++;
    end
    dropRequests();
    cnt = 0;
    while (busy && cnt < 50) begin
      tick(); cnt++;
    end
    fifo_rdata_ready = 1'b0; comp_rdata_ready = 1'b0;
    checkOutput("arb_grant_count", 64'(grants.size() - gBase), 64'd4);
    for (int i = 0; i < 4; i++)
      if (gBase + i < grants.size())
        checkOutput($sformatf("arb_grant%0d", i), 64'(grants[gBase + i]), 64'(i % 2));
    checkOutput("arb_burst_done", 64'(burstDoneCnt - bdStart), 64'd4);

    // Table of single and multi-word bursts.
    for (int i = 0; i < 8; i++) applyStimulus(i, vecs[i]);

    // Reset in the middle of a read burst that is stalled on rdata_ready.
    bdStart = burstDoneCnt;
    toStart = timeoutCnt;
    tick();
    fifo_req_valid = 1'b1; fifo_req_write = 1'b0; fifo_req_addr = 10'd1022; fifo_req_len = 8'd3;
    #1;
    cnt = 0;
    while (!fifo_req_ready && cnt < 50) begin
      tick(); cnt++;
    end
    tick();
    dropRequests();
    cnt = 0;
    while (!fifo_rdata_valid && cnt < 50) begin
      tick(); cnt++;
    end
    checkOutput("rst_burst_started", 64'(fifo_rdata), 64'h01);
    rst = 1'b1;
    tick();
    checkOutput("rst_outputs_c1", allOutputs(), 64'd0);
    tick();
    checkOutput("rst_outputs_c2", allOutputs(), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("rst_no_burst_done", 64'(burstDoneCnt - bdStart), 64'd0);
    checkOutput("rst_no_timeout", 64'(timeoutCnt - toStart), 64'd0);
    applyStimulus(8, postReset);

    // Timeout: the buffer never answers the read strobe.
    withhold = 1'b1;
    bdStart = burstDoneCnt;
    toStart = timeoutCnt;
    tick();
    fifo_req_valid = 1'b1; fifo_req_write = 1'b0; fifo_req_addr = 10'd0; fifo_req_len = 8'd0;
    #1;
    cnt = 0;
    while (!fifo_req_ready && cnt < 50) begin
      tick(); cnt++;
    end
    tick();
    dropRequests();
    cnt = 0;
    while (timeoutCnt == toStart && cnt < 60) begin
      tick(); cnt++;
    end
    checkOutput("to_pulse_count", 64'(timeoutCnt - toStart), 64'd1);
    checkOutput("to_wait_cycles", 64'(toCycle - reCycle), 64'd15);
    checkOutput("to_idle", 64'(busy), 64'd0);
    checkOutput("to_no_rdata", 64'(fifo_rdata_valid), 64'd0);
    checkOutput("to_no_burst_done", 64'(burstDoneCnt - bdStart), 64'd0);
    withhold = 1'b0;
    applyStimulus(9, vecs[1]);

    checkOutput("exclusivity", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
